// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM encoding and round helper functions for the
// compression engine.
package sha256_pkg;
   typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

   // Eight 32-bit words; index 0 is a / H0 and sits in the top bits.
   typedef logic [0:7][31:0] wv_t;

   localparam logic [255:0] IV =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction
endpackage

// File: rtl/sha256_round_comb.sv
// One combinational SHA-256 compression round: working state a..h in,
// shifted/updated working state out.
module sha256_round_comb
   import sha256_pkg::*;
(
   input  wv_t         st_i,
   input  logic [31:0] k_i,
   input  logic [31:0] w_i,
   output wv_t         st_o
);
   logic [31:0] t1, t2;

   always_comb begin
      t1   = st_i[7] + big_sigma1(st_i[4]) + ch(st_i[4], st_i[5], st_i[6]) + k_i + w_i;
      t2   = big_sigma0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);
      st_o = {t1 + t2, st_i[0], st_i[1], st_i[2], st_i[3] + t1, st_i[4], st_i[5], st_i[6]};
   end
endmodule

// File: rtl/sha256_compress_round_stream.sv
// Iterative SHA-256 compression: one round per accepted W_t word, then a
// single FINAL cycle folds the chaining value into the registered digest.
module sha256_compress_round_stream
   import sha256_pkg::*;
(
   input  logic         CLK,
   input  logic         RST,
   input  logic         start,
   input  logic [255:0] h_in,
   input  logic         w_valid,
   input  logic [31:0]  w_in,
   output logic         w_ready,
   output logic         busy,
   output logic         digest_valid,
   output logic [255:0] digest
);
   state_t      state_q, state_d;
   logic [5:0]  t_q, t_d;
   wv_t         wk_q, wk_d, hv_q, hv_d, dig_q, dig_d, rnd_o;
   logic        dv_q, dv_d;

   sha256_round_comb u_round (
      .st_i (wk_q),
      .k_i  (K[t_q]),
      .w_i  (w_in),
      .st_o (rnd_o)
   );

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      wk_d    = wk_q;
      hv_d    = hv_q;
      dig_d   = dig_q;
      dv_d    = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            hv_d    = h_in;
            wk_d    = h_in;
            t_d     = '0;
            state_d = ROUND;
         end
         ROUND: if (w_valid) begin
            wk_d = rnd_o;
            // t returns to 0 only through the exit to FINAL
            if (t_q == 6'd63) begin
               t_d     = '0;
               state_d = FINAL;
            end else begin
               t_d = t_q + 6'd1;
            end
         end
         FINAL: begin
            for (int i = 0; i < 8; i++) dig_d[i] = hv_q[i] + wk_q[i];
            dv_d    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         t_q     <= '0;
         wk_q    <= '0;
         hv_q    <= '0;
         dig_q   <= '0;
         dv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         wk_q    <= wk_d;
         hv_q    <= hv_d;
         dig_q   <= dig_d;
         dv_q    <= dv_d;
      end
   end

   assign w_ready      = (state_q == ROUND);
   assign busy         = (state_q == ROUND) || (state_q == FINAL);
   assign digest_valid = dv_q;
   assign digest       = dig_q;
endmodule
